zjh_vote_ctrl: RTL and testbench
================================

// Module: zjh_vote_ctrl
// PURPOSE
//  Sequences one 3-voter ballot around the MAJ3 majority voter datapath.
//  Opens a timed voting window on start and latches each voter's first vote only.
//  Closes the window when all three have voted or the window expires.
//  Presents the majority result Y with a done pulse and holds it until the next ballot.
// PARAMETERS
//  WINDOW_CYC  16  voting window length in clk cycles (>=2)
//  TW          5   timer width; must satisfy 2**TW >= WINDOW_CYC
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active-high
//  start      in   1   open new ballot (sampled in IDLE only)
//  A,B,C      in   1   vote value per voter (1=yes, 0=no), sampled with its enable
//  A_en,B_en,C_en in 1 vote strobe per voter, one-cycle or level
//  busy       out  1   1 while in VOTE
//  voted      out  3   {C,B,A} voter-has-voted flags, registered
//  Y          out  1   majority result of last completed ballot
//  valid      out  1   Y is a completed-ballot result
//  done       out  1   one-cycle pulse when result is produced
//  timed_out  out  1   last ballot closed by window expiry (not all voted)
// BEHAVIOUR
//  - rst=1 (async): state=IDLE; busy, voted, Y, valid, done, timed_out,
//    vote registers and timer all 0. Release mid-ballot discards the ballot.
//  - FSM: IDLE -> VOTE -> RESULT -> IDLE.
//  - IDLE: busy=0. start=1 at edge -> VOTE next cycle; same edge clears voted,
//    vote regs, valid, Y, timed_out; timer <= WINDOW_CYC-1.
//  - VOTE: busy=1. Per voter X: if X_en && !voted[X] then vote_reg[X]<=X,
//    voted[X]<=1. Later X_en while voted[X]=1 is ignored (no re-vote).
//    Simultaneous enables from several voters are all accepted.
//    timer decrements each VOTE cycle.
//    Exit to RESULT when voted==3'b111 (registered) or timer==0.
//    An enable in the timer==0 cycle is still latched and counted.
//    All voted on the same edge as timer reaching 0: timed_out=0.
//    start is ignored in VOTE and RESULT.
//  - RESULT (1 cycle): Y <= MAJ3 of (vote_reg & voted); absent voter counts as no.
//    valid<=1, done<=1 for exactly this one registered cycle.
//    timed_out <= (voted!=3'b111). Next state IDLE.
//  - Y/valid/timed_out hold until the next accepted start.
//  - Latency: last vote strobe edge -> done high 2 cycles later.
//    start edge with no votes -> done after WINDOW_CYC+1 cycles.
//  - Majority as sum>=2 on 2-bit count or MAJ3 gate form; both equivalent.
// TESTING
//  1 reset mid-VOTE with voted=3'b011 -> all outputs 0 immediately, state IDLE.
//  2 start; A=1,B=1,C=0 strobed cycles 1,2,3 -> done 2 cycles after C_en;
//    Y=1, timed_out=0, voted=111.
//  3 start; only A=1 voted -> timed_out=1, Y=0, done at cycle WINDOW_CYC+1.
//  4 A_en twice (A=1 then A=0), B=0, C=0 -> first vote kept, Y=0.
//    Recheck with B=1: Y=1.
//  5 A_en,B_en,C_en same cycle, values 1,0,1 -> Y=1, done 2 cycles later.
//  6 start held high through VOTE/RESULT -> no restart until IDLE.
//    Then new ballot clears valid.

Source files
------------

// File: rtl/zjh_vote_if.sv
// Ballot handshake bundle between a vote source (master) and the vote controller (slave).
interface zjh_vote_if;
  logic       start;
  logic       A, B, C;
  logic       A_en, B_en, C_en;
  logic       busy;
  logic [2:0] voted;
  logic       Y;
  logic       valid;
  logic       done;
  logic       timed_out;

  modport master (
    output start, A, B, C, A_en, B_en, C_en,
    input  busy, voted, Y, valid, done, timed_out
  );

  modport slave (
    input  start, A, B, C, A_en, B_en, C_en,
    output busy, voted, Y, valid, done, timed_out
  );
endinterface

// File: rtl/zjh_vote_ctrl.sv
// Three-voter ballot sequencer: timed voting window, first-vote-only latching,
// majority result with a one-cycle done pulse held until the next ballot.
module zjh_vote_ctrl #(
  parameter int WINDOW_CYC = 16,
  parameter int TW         = 5
) (
  input  logic       clk,
  input  logic       rst,
  zjh_vote_if.slave  vif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTE   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [2:0]    voted;
  logic [2:0]    vote_reg;
  logic [2:0]    en, val, accept;
  logic          y_r, valid_r, done_r, timed_out_r;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign en     = {vif.C_en, vif.B_en, vif.A_en};
  assign val    = {vif.C, vif.B, vif.A};
  // Only a voter's first strobe in the window is accepted.
  assign accept = en & ~voted;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vif.start) state_nxt = VOTE;
      VOTE:    if (voted == 3'b111 || timer == '0) state_nxt = RESULT;
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      voted       <= '0;
      vote_reg    <= '0;
      y_r         <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
      timed_out_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (vif.start) begin
            timer       <= TW'(WINDOW_CYC - 1);
            voted       <= '0;
            vote_reg    <= '0;
            y_r         <= 1'b0;
            valid_r     <= 1'b0;
            timed_out_r <= 1'b0;
          end
        end
        VOTE: begin
          // Strobes in the final (timer==0) cycle still count toward the ballot.
          voted    <= voted | en;
          vote_reg <= (vote_reg & ~accept) | (val & accept);
          if (timer != '0) timer <= timer - 1'b1;
        end
        RESULT: begin
          y_r         <= maj3(vote_reg & voted);
          valid_r     <= 1'b1;
          done_r      <= 1'b1;
          timed_out_r <= (voted != 3'b111);
        end
        default: ;
      endcase
    end
  end

  assign vif.busy      = (state == VOTE);
  assign vif.voted     = voted;
  assign vif.Y         = y_r;
  assign vif.valid     = valid_r;
  assign vif.done      = done_r;
  assign vif.timed_out = timed_out_r;

endmodule

// File: tb/tb_zjh_vote_ctrl.sv
// Bench for zjh_vote_ctrl: ballot-level reference model compared every cycle,
// plus directed ballots with hand-computed latencies and results.
module tb_zjh_vote_ctrl;
  localparam int WINDOW_CYC = 16;
  localparam int TW         = 5;

  logic clk;
  logic rst;
  zjh_vote_if vif();

  zjh_vote_ctrl #(.WINDOW_CYC(WINDOW_CYC), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a ballot is a window of WINDOW_CYC sampling edges, closed early
  // once every voter is already counted; the result follows one edge after closing.
  bit         m_open, m_close, m_y, m_valid, m_done, m_to;
  int         m_el;
  logic [2:0] m_voted, m_vals;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_open = 0; m_close = 0; m_y = 0; m_valid = 0; m_done = 0; m_to = 0;
      m_el = 0; m_voted = '0; m_vals = '0;
    end else begin
      logic [2:0] en, v, acc;
      bit         closing;
      int         cnt;
      en = {vif.C_en, vif.B_en, vif.A_en};
      v  = {vif.C, vif.B, vif.A};
      m_done = 0;
      if (m_close) begin
        m_close = 0;
        cnt = 0;
        for (int i = 0; i < 3; i++) if (m_voted[i] && m_vals[i]) cnt++;
        m_y     = (cnt >= 2);
        m_valid = 1;
        m_done  = 1;
        m_to    = (m_voted != 3'b111);
      end else if (m_open) begin
        closing = (m_voted == 3'b111) || (m_el == WINDOW_CYC - 1);
        for (int i = 0; i < 3; i++) begin
          acc[i] = en[i] && !m_voted[i];
          if (acc[i]) begin
            m_voted[i] = 1'b1;
            m_vals[i]  = v[i];
          end
        end
        m_el++;
        if (closing) begin
          m_open  = 0;
          m_close = 1;
        end
      end else if (vif.start) begin
        m_open = 1; m_el = 0; m_voted = '0; m_vals = '0;
        m_valid = 0; m_y = 0; m_to = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("busy",      {31'd0, vif.busy},      {31'd0, m_open});
      chk("voted",     {29'd0, vif.voted},     {29'd0, m_voted});
      chk("Y",         {31'd0, vif.Y},         {31'd0, m_y});
      chk("valid",     {31'd0, vif.valid},     {31'd0, m_valid});
      chk("done",      {31'd0, vif.done},      {31'd0, m_done});
      chk("timed_out", {31'd0, vif.timed_out}, {31'd0, m_to});
    end
  end

  task automatic open_ballot();
    @(negedge clk); vif.start = 1'b1;
    @(negedge clk); vif.start = 1'b0;
  endtask

  task automatic drive_votes(input logic [2:0] en, input logic [2:0] v);
    @(negedge clk);
    {vif.C_en, vif.B_en, vif.A_en} = en;
    {vif.C, vif.B, vif.A}          = v;
    @(negedge clk);
    {vif.C_en, vif.B_en, vif.A_en} = 3'b000;
  endtask

  // Counts rising edges until done is seen; -1 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (vif.done) return;
    end
    n = -1;
  endtask

  task automatic chk_result(input string nm, input int lat, input int lat_exp,
                            input logic y, input logic to, input logic [2:0] vt);
    chk({nm, "_latency"},   lat, lat_exp);
    chk({nm, "_Y"},         {31'd0, vif.Y},         {31'd0, y});
    chk({nm, "_valid"},     {31'd0, vif.valid},     32'd1);
    chk({nm, "_timed_out"}, {31'd0, vif.timed_out}, {31'd0, to});
    chk({nm, "_voted"},     {29'd0, vif.voted},     {29'd0, vt});
  endtask

  int n;

  initial begin
    rst = 1'b1;
    vif.start = 0; vif.A = 0; vif.B = 0; vif.C = 0;
    vif.A_en = 0; vif.B_en = 0; vif.C_en = 0;
    #12;
    chk("rst_busy",  {31'd0, vif.busy},  32'd0);
    chk("rst_voted", {29'd0, vif.voted}, 32'd0);
    chk("rst_valid", {31'd0, vif.valid}, 32'd0);
    chk("rst_done",  {31'd0, vif.done},  32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Sequential votes A=1, B=1, C=0; done two edges after the last strobe.
    open_ballot();
    drive_votes(3'b001, 3'b001);
    drive_votes(3'b010, 3'b010);
    drive_votes(3'b100, 3'b000);
    wait_done(n);
    chk_result("seq", n, 2, 1'b1, 1'b0, 3'b111);

    // Only A votes: window expires, done WINDOW_CYC+1 edges after start.
    open_ballot();
    vif.A = 1'b1; vif.A_en = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      vif.A_en = 1'b0;
      n++;
      if (vif.done) break;
    end
    if (n >= 40) n = -1;
    chk_result("timeout", n, WINDOW_CYC + 1, 1'b0, 1'b1, 3'b001);

    // Re-vote by A is ignored: A=1 kept, B=0, C=0.
    open_ballot();
    drive_votes(3'b001, 3'b001);
    drive_votes(3'b001, 3'b000);
    drive_votes(3'b010, 3'b000);
    drive_votes(3'b100, 3'b000);
    wait_done(n);
    chk_result("revote0", n, 2, 1'b0, 1'b0, 3'b111);

    open_ballot();
    drive_votes(3'b001, 3'b001);
    drive_votes(3'b001, 3'b000);
    drive_votes(3'b010, 3'b010);
    drive_votes(3'b100, 3'b000);
    wait_done(n);
    chk_result("revote1", n, 2, 1'b1, 1'b0, 3'b111);

    // All three in one cycle, values C=1 B=0 A=1.
    open_ballot();
    drive_votes(3'b111, 3'b101);
    wait_done(n);
    chk_result("simul", n, 2, 1'b1, 1'b0, 3'b111);

    // All strobes land exactly in the last window cycle: counted, no timeout.
    open_ballot();
    repeat (14) @(negedge clk);
    drive_votes(3'b111, 3'b110);
    wait_done(n);
    chk_result("lastcyc", n, 1, 1'b1, 1'b0, 3'b111);

    // start held high: ignored in VOTE/RESULT, then re-accepted from IDLE.
    @(negedge clk); vif.start = 1'b1;
    drive_votes(3'b111, 3'b111);
    wait_done(n);
    chk_result("hold", n, 2, 1'b1, 1'b0, 3'b111);
    @(posedge clk); #1;
    chk("hold_restart_valid", {31'd0, vif.valid}, 32'd0);
    chk("hold_restart_busy",  {31'd0, vif.busy},  32'd1);
    chk("hold_restart_voted", {29'd0, vif.voted}, 32'd0);
    @(negedge clk); vif.start = 1'b0;
    drive_votes(3'b111, 3'b000);
    wait_done(n);
    chk_result("hold2", n, 2, 1'b0, 1'b0, 3'b111);

    // Asynchronous reset in the middle of a ballot with A and B counted.
    open_ballot();
    drive_votes(3'b001, 3'b001);
    drive_votes(3'b010, 3'b000);
    chk("pre_rst_voted", {29'd0, vif.voted}, 32'd3);
    chk("pre_rst_busy",  {31'd0, vif.busy},  32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",      {31'd0, vif.busy},      32'd0);
    chk("mid_rst_voted",     {29'd0, vif.voted},     32'd0);
    chk("mid_rst_Y",         {31'd0, vif.Y},         32'd0);
    chk("mid_rst_valid",     {31'd0, vif.valid},     32'd0);
    chk("mid_rst_done",      {31'd0, vif.done},      32'd0);
    chk("mid_rst_timed_out", {31'd0, vif.timed_out}, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", {31'd0, vif.busy}, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
